div_low: RTL
============

DIV_LOW -- requirements
Module: div_low

Interface
REQ-001 SHALL provide parameter N, default 8, dividend and quotient width.
REQ-002 SHALL provide parameter M, default 4, divisor and remainder width (M <= N).
REQ-003 SHALL provide port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL provide port data_rdy, input, 1, operands valid and request a division.
REQ-006 SHALL provide port dividend, input, N, unsigned dividend.
REQ-007 SHALL provide port divisor, input, M, unsigned divisor.
REQ-008 SHALL provide port res_rdy, output, 1, one-cycle pulse marking a valid result.
REQ-009 SHALL provide port quotient, output, N, unsigned quotient.
REQ-010 SHALL provide port remainder, output, M, unsigned remainder.
REQ-011 SHALL provide port dz, output, 1, divide-by-zero flag, valid when res_rdy is high.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-013 IDLE: data_rdy high at edge E0 SHALL latch dividend and divisor, clear the M+1-bit partial remainder and enter CALC.
REQ-014 data_rdy SHALL be ignored in CALC and DONE; no queuing, and latched operands are not disturbed.
REQ-015 CALC SHALL run restoring division MSB-first, one quotient bit per clock, N iterations at edges E1..EN, using an iteration counter of width clog2(N+1).
REQ-016 Each iteration: shift the partial remainder left with the next dividend bit; if it is >= divisor, subtract the divisor and set the quotient bit to 1, else set it to 0.
REQ-017 At EN the FSM SHALL enter DONE and register quotient, remainder and dz=0; res_rdy SHALL be high for exactly the one cycle following EN.
REQ-018 At the next edge DONE SHALL return to IDLE with res_rdy=0; the earliest next accept is edge EN+2.
REQ-019 quotient, remainder and dz SHALL hold their values until the next result is registered or reset occurs.
REQ-020 Results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor whenever divisor != 0.
REQ-021 With divisor=0 and no zero check, the N iterations SHALL yield quotient all ones and remainder = dividend[M-1:0], with dz=0.

Reset
REQ-022 rst high at an edge SHALL force IDLE and clear res_rdy, quotient, remainder, dz, the counter and the partial remainder to 0.
REQ-023 rst SHALL take priority over data_rdy and over any state, including mid-CALC; an aborted division SHALL produce no res_rdy.

Configuration
REQ-024 Macro DIV_ZERO_CHK_EN defined: divisor=0 at accept edge E0 SHALL bypass CALC, go straight to DONE, and register quotient all ones, remainder = dividend[M-1:0] and dz=1; res_rdy is high in the cycle after E0.
REQ-025 Macro DIV_ZERO_CHK_EN undefined: the dz port SHALL remain and be tied to 0; divisor=0 follows REQ-021 with N-cycle latency.

Structure
REQ-026 Package div_pkg SHALL hold the FSM state typedef (IDLE, CALC, DONE) and the default N/M constants.
REQ-027 One combinational sub-module div_step SHALL implement a single shift/compare/subtract iteration; div_low SHALL instantiate it once and sequence it.
REQ-028 RTL SHALL be synthesizable; no latches; no combinational path from inputs to outputs.

Verification (N=8, M=4)
REQ-029 SHALL check reset and plain division: release rst, then dividend 25, divisor 5 -> res_rdy one cycle after E8, quotient 5, remainder 0, dz 0.
REQ-030 SHALL check back-to-back divisions in handshake order: 16/10, 10/4, 15/7, 215/9 -> (1,6), (2,2), (2,1), (23,8), each with one-cycle res_rdy.
REQ-031 SHALL check boundaries: 255/1 -> (255,0); 7/15 -> (0,7); 0/3 -> (0,0).
REQ-032 SHALL check divide-by-zero: 100/0 -> quotient 255, remainder 4; with DIV_ZERO_CHK_EN dz=1 and res_rdy one cycle after E0, without it dz=0 and res_rdy after E8.
REQ-033 SHALL check data_rdy while busy: pulse data_rdy with 9/3 during CALC of 200/7 -> only (28,4) is produced and 9/3 is dropped.
REQ-034 SHALL check reset mid-operation: rst high at E4 of 215/9 -> IDLE, all outputs 0, no res_rdy; a following 25/5 returns (5,0).

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared FSM state encoding and default operand widths for the divider.
package div_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int N_DEF = 8;
    localparam int M_DEF = 4;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (shift in a dividend bit, compare, subtract).
module div_step
    import div_pkg::*;
#(
    parameter int M = M_DEF
) (
    input  logic [M:0]   i_rem,
    input  logic         i_bit,
    input  logic [M-1:0] i_divisor,
    output logic [M:0]   o_rem,
    output logic         o_q
);
    logic [M+1:0] w_sh;
    assign w_sh  = {i_rem, i_bit};
    assign o_q   = w_sh >= {2'b00, i_divisor};
    assign o_rem = o_q ? (M+1)'(w_sh - {2'b00, i_divisor}) : w_sh[M:0];
endmodule

// File: rtl/div_low.sv
// div_low: sequential restoring divider, one quotient bit per clock.
// Defining DIV_ZERO_CHK_EN adds a divide-by-zero bypass that drives dz.
module div_low
    import div_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         data_rdy,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic         res_rdy,
    output logic [N-1:0] quotient,
    output logic [M-1:0] remainder,
    output logic         dz
);
    localparam int CW = $clog2(N + 1);
    state_t         r_state, w_next;
    logic [N-1:0]   r_dvd, r_quot;
    logic [M-1:0]   r_dsr, r_rem_o;
    logic [M:0]     r_rem, w_rem;
    logic [CW-1:0]  r_cnt;
    logic           r_res_rdy, w_q, w_last, w_zero, w_accept;
    div_step #(.M(M)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_dvd[N-1]),
        .i_divisor (r_dsr),
        .o_rem     (w_rem),
        .o_q       (w_q)
    );
    assign w_last   = r_cnt == CW'(N - 1);
    assign w_accept = (r_state == IDLE) && data_rdy;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (data_rdy) w_next = w_zero ? DONE : CALC;
            CALC:    if (w_last) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
    end
    // The dividend register doubles as the quotient shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd     <= '0;
            r_dsr     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem_o   <= '0;
            r_res_rdy <= 1'b0;
        end else begin
            r_res_rdy <= (w_next == DONE) && (r_state != DONE);
            if (w_accept) begin
                r_dvd <= dividend;
                r_dsr <= divisor;
                r_rem <= '0;
                r_cnt <= '0;
                if (w_zero) begin
                    r_quot  <= '1;
                    r_rem_o <= dividend[M-1:0];
                end
            end else if (r_state == CALC) begin
                r_dvd <= {r_dvd[N-2:0], w_q};
                r_rem <= w_rem;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_quot  <= {r_dvd[N-2:0], w_q};
                    r_rem_o <= w_rem[M-1:0];
                end
            end
        end
    end
`ifdef DIV_ZERO_CHK_EN
    logic r_dz;
    assign w_zero = divisor == '0;
    always_ff @(posedge clk) begin
        if (rst)
            r_dz <= 1'b0;
        else if (w_accept && w_zero)
            r_dz <= 1'b1;
        else if (r_state == CALC && w_last)
            r_dz <= 1'b0;
    end
    assign dz = r_dz;
`else
    assign w_zero = 1'b0;
    assign dz     = 1'b0;
`endif
    assign res_rdy   = r_res_rdy;
    assign quotient  = r_quot;
    assign remainder = r_rem_o;
endmodule
